// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor control unit:
// opcodes, FSM state encoding and instruction-register field positions.
package proc_pkg;

    // Instruction opcodes held in the top three bits of IR
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    // IR fields are 3 bits wide, located by their distance below the IR MSB
    localparam int FIELD_W   = 3;
    localparam int IR_OP_TOP = 0;
    localparam int IR_X_TOP  = 3;
    localparam int IR_Y_TOP  = 6;

    // Register 7 is the program counter
    localparam int PC_IDX = 7;

    typedef enum logic [2:0] {
        S_FETCH0 = 3'd0,
        S_FWAIT  = 3'd1,
        S_FETCH2 = 3'd2,
        S_EX1    = 3'd3,
        S_EWAIT  = 3'd4,
        S_EX3    = 3'd5
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-bit register field to one-hot 8-bit select, used for the RIn/ROut vectors.
module dec3to8 (
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    assign o_onehot = 8'b0000_0001 << i_sel;

endmodule

// File: rtl/proc_control_fsm.sv
// Multicycle control unit: fetches the instruction at PC (R7), latches IR,
// then sequences the datapath strobes for one instruction.
// Optional feature: define CTRL_MVNZ_EN to make opcode 110 a conditional
// move on GNZ; otherwise 110 behaves as a NOP and GNZ is ignored.
//
// state  | meaning
// FETCH0 | idle / put PC on the address bus and bump PC when Run is high
// FWAIT  | memory read latency for the instruction fetch
// FETCH2 | latch DIN into IR
// EX1    | first execute cycle (single-cycle ops finish here)
// EWAIT  | memory latency for mvi/ld, or ALU operand cycle for add/sub
// EX3    | final write-back / store cycle
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int IR_W     = 16
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [IR_W-1:0] DIN,
    input  logic            GNZ,
    output logic            IRIn,
    output logic [7:0]      RIn,
    output logic [7:0]      ROut,
    output logic            GOut,
    output logic            DinOut,
    output logic            AIn,
    output logic            GIn,
    output logic            AddSub,
    output logic            IncrPc,
    output logic            ADDRIn,
    output logic            DOUTIn,
    output logic            W_D,
    output logic            Done
);

    localparam int CNT_W = $clog2(MEM_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);
    localparam logic [7:0]       PC_SEL    = 8'(1) << PC_IDX;

    state_t           r_state;
    state_t           w_next;
    logic [IR_W-1:0]  r_ir;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_next;

    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [7:0] w_x_oh;
    logic [7:0] w_y_oh;

    logic       w_ir_in;
    logic [7:0] w_rin;
    logic [7:0] w_rout;
    logic       w_gout;
    logic       w_din_out;
    logic       w_ain;
    logic       w_gin;
    logic       w_addsub;
    logic       w_incr_pc;
    logic       w_addr_in;
    logic       w_dout_in;
    logic       w_wd;
    logic       w_done;

    assign w_op = r_ir[IR_W-1-IR_OP_TOP -: FIELD_W];
    assign w_x  = r_ir[IR_W-1-IR_X_TOP  -: FIELD_W];
    assign w_y  = r_ir[IR_W-1-IR_Y_TOP  -: FIELD_W];

    // Low IR bits carry no control meaning
    logic w_unused_ir;
    assign w_unused_ir = ^r_ir[IR_W-1-IR_Y_TOP-FIELD_W:0];

`ifndef CTRL_MVNZ_EN
    logic w_unused_gnz;
    assign w_unused_gnz = GNZ;
`endif

    dec3to8 u_dec_x (
        .i_sel    (w_x),
        .o_onehot (w_x_oh)
    );

    dec3to8 u_dec_y (
        .i_sel    (w_y),
        .o_onehot (w_y_oh)
    );

    // State, instruction register and memory wait counter
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_FETCH0;
            r_ir    <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            if (w_ir_in) begin
                r_ir <= DIN;
            end
        end
    end

    // Next-state and strobe decode from state, IR, Run and GNZ
    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        w_ir_in     = 1'b0;
        w_rin       = '0;
        w_rout      = '0;
        w_gout      = 1'b0;
        w_din_out   = 1'b0;
        w_ain       = 1'b0;
        w_gin       = 1'b0;
        w_addsub    = 1'b0;
        w_incr_pc   = 1'b0;
        w_addr_in   = 1'b0;
        w_dout_in   = 1'b0;
        w_wd        = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_FETCH0: begin
                if (Run) begin
                    w_rout      = PC_SEL;
                    w_addr_in   = 1'b1;
                    w_incr_pc   = 1'b1;
                    w_wcnt_next = WAIT_LOAD;
                    w_next      = S_FWAIT;
                end
            end

            S_FWAIT: begin
                if (r_wcnt == '0) begin
                    w_next = S_FETCH2;
                end else begin
                    w_wcnt_next = r_wcnt - CNT_W'(1);
                end
            end

            S_FETCH2: begin
                w_ir_in = 1'b1;
                w_next  = S_EX1;
            end

            S_EX1: begin
                case (w_op)
                    OP_MV: begin
                        w_rout = w_y_oh;
                        w_rin  = w_x_oh;
                        w_done = 1'b1;
                        w_next = S_FETCH0;
                    end
                    OP_MVI: begin
                        w_rout      = PC_SEL;
                        w_addr_in   = 1'b1;
                        w_incr_pc   = 1'b1;
                        w_wcnt_next = WAIT_LOAD;
                        w_next      = S_EWAIT;
                    end
                    OP_ADD, OP_SUB: begin
                        // ALU operand cycle is not a memory access: one EWAIT cycle only
                        w_rout      = w_x_oh;
                        w_ain       = 1'b1;
                        w_wcnt_next = '0;
                        w_next      = S_EWAIT;
                    end
                    OP_LD: begin
                        w_rout      = w_y_oh;
                        w_addr_in   = 1'b1;
                        w_wcnt_next = WAIT_LOAD;
                        w_next      = S_EWAIT;
                    end
                    OP_ST: begin
                        w_rout    = w_y_oh;
                        w_addr_in = 1'b1;
                        w_next    = S_EX3;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        if (GNZ) begin
                            w_rout = w_y_oh;
                            w_rin  = w_x_oh;
                        end
                        w_done = 1'b1;
                        w_next = S_FETCH0;
                    end
`endif
                    default: begin
                        w_done = 1'b1;
                        w_next = S_FETCH0;
                    end
                endcase
            end

            S_EWAIT: begin
                if (w_op == OP_ADD || w_op == OP_SUB) begin
                    w_rout   = w_y_oh;
                    w_gin    = 1'b1;
                    w_addsub = w_op[0];
                end
                if (r_wcnt == '0) begin
                    w_next = S_EX3;
                end else begin
                    w_wcnt_next = r_wcnt - CNT_W'(1);
                end
            end

            S_EX3: begin
                case (w_op)
                    OP_MVI, OP_LD: begin
                        w_din_out = 1'b1;
                        w_rin     = w_x_oh;
                    end
                    OP_ADD, OP_SUB: begin
                        w_gout = 1'b1;
                        w_rin  = w_x_oh;
                    end
                    OP_ST: begin
                        w_rout    = w_x_oh;
                        w_dout_in = 1'b1;
                        w_wd      = 1'b1;
                    end
                    default: begin
                    end
                endcase
                w_done = 1'b1;
                w_next = S_FETCH0;
            end

            default: begin
                w_next = S_FETCH0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, independent of the clock
    assign IRIn   = Resetn & w_ir_in;
    assign RIn    = {8{Resetn}} & w_rin;
    assign ROut   = {8{Resetn}} & w_rout;
    assign GOut   = Resetn & w_gout;
    assign DinOut = Resetn & w_din_out;
    assign AIn    = Resetn & w_ain;
    assign GIn    = Resetn & w_gin;
    assign AddSub = Resetn & w_addsub;
    assign IncrPc = Resetn & w_incr_pc;
    assign ADDRIn = Resetn & w_addr_in;
    assign DOUTIn = Resetn & w_dout_in;
    assign W_D    = Resetn & w_wd;
    assign Done   = Resetn & w_done;

endmodule
